// File: rtl/anode_decoder_if.sv
// Digit-select bus between the display scan logic and the anode decoder.
// The scan logic drives index, enable and mask; the decoder returns anode enables and gap status.
interface anode_decoder_if;
  logic [2:0] data;
  logic       en;
  logic [7:0] digit_mask;
  logic [7:0] an;
  logic       blanking;

  modport master (output data, en, digit_mask, input an, blanking);
  modport slave  (input data, en, digit_mask, output an, blanking);
endinterface

// File: rtl/anode_decoder.sv
// Registered 3-to-8 anode decoder with enable, blank mask and optional anti-ghost gap on index change.
// Latency 1 cycle (BLANK_CYCLES+1 edges to a new digit when the gap is enabled); no backpressure.
module anode_decoder #(
  parameter int ACTIVE_LOW   = 1,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 0
) (
  input logic            clk,
  input logic            rst_n,
  anode_decoder_if.slave bus
);

  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [7:0]    OFF      = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [CW-1:0] GAP_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic          GAP_BLANK = (BLANK_CYCLES > 1);

  typedef enum logic {DRIVE, GAP} state_t;

  state_t        state;
  logic [2:0]    cur_sel, cur_sel_nxt;
  logic [CW-1:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]    an_q, an_nxt;
  logic          blank_q, blank_nxt;
  logic [7:0]    onehot;

  // Active-high one-hot, limited to populated digits and the blank mask.
  always_comb begin
    onehot = 8'h00;
    if (int'(bus.data) < NUM_DIGITS) onehot[bus.data] = 1'b1;
    onehot = onehot & bus.digit_mask;
  end

  always_comb begin
    state       = (gap_cnt != '0) ? GAP : DRIVE;
    cur_sel_nxt = cur_sel;
    gap_cnt_nxt = gap_cnt;
    an_nxt      = OFF;
    blank_nxt   = 1'b0;
    if (!bus.en) begin
      cur_sel_nxt = bus.data;
      gap_cnt_nxt = '0;
    end else if ((BLANK_CYCLES > 0) && (bus.data != cur_sel)) begin
      cur_sel_nxt = bus.data;
      gap_cnt_nxt = GAP_LOAD;
      blank_nxt   = GAP_BLANK;
    end else if (state == GAP) begin
      gap_cnt_nxt = gap_cnt - 1'b1;
      blank_nxt   = (gap_cnt > CW'(1));
    end else begin
      cur_sel_nxt = bus.data;
      an_nxt      = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_sel <= 3'd0;
      gap_cnt <= '0;
      an_q    <= OFF;
      blank_q <= 1'b0;
    end else begin
      cur_sel <= cur_sel_nxt;
      gap_cnt <= gap_cnt_nxt;
      an_q    <= an_nxt;
      blank_q <= blank_nxt;
    end
  end

  assign bus.an       = an_q;
  assign bus.blanking = blank_q;

endmodule

// File: tb/tb_anode_decoder.sv
// Self-checking bench: directed vector table, hand-written gap sequences, and randomized run
// against a cycle-age reference model across five parameterisations sharing one stimulus.
module tb_anode_decoder;
  localparam int NI  = 5;
  localparam int BIG = 1000;
  localparam int P_AL[NI] = '{1, 1, 1, 0, 0};
  localparam int P_ND[NI] = '{8, 8, 4, 8, 5};
  localparam int P_BC[NI] = '{0, 2, 0, 0, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] data;
  logic [7:0] mask;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_sel[NI];
  int         m_age[NI];
  logic [7:0] m_an[NI];
  logic       m_bl[NI];
  logic [7:0] an_o[NI];
  logic       bl_o[NI];

  always #5 clk = ~clk;

  anode_decoder_if ifc0 ();
  anode_decoder_if ifc1 ();
  anode_decoder_if ifc2 ();
  anode_decoder_if ifc3 ();
  anode_decoder_if ifc4 ();

  assign ifc0.data = data; assign ifc0.en = en; assign ifc0.digit_mask = mask;
  assign ifc1.data = data; assign ifc1.en = en; assign ifc1.digit_mask = mask;
  assign ifc2.data = data; assign ifc2.en = en; assign ifc2.digit_mask = mask;
  assign ifc3.data = data; assign ifc3.en = en; assign ifc3.digit_mask = mask;
  assign ifc4.data = data; assign ifc4.en = en; assign ifc4.digit_mask = mask;

  assign an_o[0] = ifc0.an; assign bl_o[0] = ifc0.blanking;
  assign an_o[1] = ifc1.an; assign bl_o[1] = ifc1.blanking;
  assign an_o[2] = ifc2.an; assign bl_o[2] = ifc2.blanking;
  assign an_o[3] = ifc3.an; assign bl_o[3] = ifc3.blanking;
  assign an_o[4] = ifc4.an; assign bl_o[4] = ifc4.blanking;

  anode_decoder #(.ACTIVE_LOW(1), .NUM_DIGITS(8), .BLANK_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  anode_decoder #(.ACTIVE_LOW(1), .NUM_DIGITS(8), .BLANK_CYCLES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
  anode_decoder #(.ACTIVE_LOW(1), .NUM_DIGITS(4), .BLANK_CYCLES(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));
  anode_decoder #(.ACTIVE_LOW(0), .NUM_DIGITS(8), .BLANK_CYCLES(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(ifc3.slave));
  anode_decoder #(.ACTIVE_LOW(0), .NUM_DIGITS(5), .BLANK_CYCLES(3)) u4 (.clk(clk), .rst_n(rst_n), .bus(ifc4.slave));

  typedef struct {
    logic       r;
    logic       e;
    logic [2:0] d;
    logic [7:0] m;
    logic [7:0] ea;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [2:0] d, logic [7:0] m, logic [7:0] ea, logic eb);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.m = m; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic logic [7:0] off_val(int i);
    return (P_AL[i] != 0) ? 8'hFF : 8'h00;
  endfunction

  // Digit s lit if populated and unmasked; polarity applied last.
  function automatic logic [7:0] ref_decode(int i, int s, logic [7:0] m);
    logic [7:0] v;
    v = 8'h00;
    if (s < P_ND[i] && m[s]) v = 8'(1 << s);
    return (P_AL[i] != 0) ? ~v : v;
  endfunction

  // m_age counts edges since the last index change; the display is dark while age < BLANK_CYCLES.
  task automatic model_step(int i);
    if (!rst_n) begin
      m_sel[i] = 0; m_age[i] = BIG; m_an[i] = off_val(i); m_bl[i] = 1'b0;
    end else if (!en) begin
      m_sel[i] = int'(data); m_age[i] = BIG; m_an[i] = off_val(i); m_bl[i] = 1'b0;
    end else begin
      if (P_BC[i] > 0 && int'(data) != m_sel[i]) begin
        m_sel[i] = int'(data);
        m_age[i] = 0;
      end else if (m_age[i] < BIG) begin
        m_age[i] = m_age[i] + 1;
      end
      if (m_age[i] < P_BC[i]) begin
        m_an[i] = off_val(i);
        m_bl[i] = (m_age[i] < P_BC[i] - 1);
      end else begin
        m_an[i] = ref_decode(i, int'(data), mask);
        m_bl[i] = 1'b0;
        m_sel[i] = int'(data);
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic apply(logic r, logic e, logic [2:0] d, logic [7:0] m);
    rst_n = r; en = e; data = d; mask = m;
    tick();
  endtask

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; data = 3'd3; mask = 8'hFF;

    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hFF, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hFF, 8'hFF, 1'b0));
    for (int s = 0; s < 8; s++)
      tbl.push_back(mk(1'b1, 1'b1, 3'(s), 8'hFF, ~8'(1 << s), 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd2, 8'hFB, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'hFB, 8'hFD, 1'b0));

    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].e, tbl[k].d, tbl[k].m);
      check8($sformatf("vec%0d_an", k), an_o[0], tbl[k].ea);
      check1($sformatf("vec%0d_blank", k), bl_o[0], tbl[k].eb);
    end

    // Digit-count limit and non-inverted polarity.
    apply(1'b1, 1'b1, 3'd6, 8'hFF);
    check8("nd4_idx6", an_o[2], 8'hFF);
    apply(1'b1, 1'b1, 3'd3, 8'hFF);
    check8("nd4_idx3", an_o[2], 8'hF7);
    check8("al0_idx3", an_o[3], 8'h08);

    // Two-cycle gap on 0 -> 5.
    apply(1'b0, 1'b1, 3'd0, 8'hFF);
    apply(1'b1, 1'b1, 3'd0, 8'hFF);
    check8("gap_pre_an", an_o[1], 8'hFE);
    apply(1'b1, 1'b1, 3'd5, 8'hFF);
    check8("gap1_an", an_o[1], 8'hFF); check1("gap1_bl", bl_o[1], 1'b1);
    tick();
    check8("gap2_an", an_o[1], 8'hFF); check1("gap2_bl", bl_o[1], 1'b0);
    tick();
    check8("gap_done_an", an_o[1], 8'hDF); check1("gap_done_bl", bl_o[1], 1'b0);

    // Change during the gap restarts it.
    apply(1'b1, 1'b1, 3'd2, 8'hFF);
    check8("rs1_an", an_o[1], 8'hFF); check1("rs1_bl", bl_o[1], 1'b1);
    apply(1'b1, 1'b1, 3'd6, 8'hFF);
    check8("rs2_an", an_o[1], 8'hFF); check1("rs2_bl", bl_o[1], 1'b1);
    tick();
    check8("rs3_an", an_o[1], 8'hFF); check1("rs3_bl", bl_o[1], 1'b0);
    tick();
    check8("rs4_an", an_o[1], 8'hBF);
    repeat (3) tick();
    check8("hold_an", an_o[1], 8'hBF);

    // Reset mid-gap aborts it and clears the stored index.
    apply(1'b1, 1'b1, 3'd1, 8'hFF);
    check1("mid_bl", bl_o[1], 1'b1);
    apply(1'b0, 1'b1, 3'd1, 8'hFF);
    check8("rst_gap_an", an_o[1], 8'hFF); check1("rst_gap_bl", bl_o[1], 1'b0);
    apply(1'b1, 1'b1, 3'd1, 8'hFF);
    check8("post_rst_an", an_o[1], 8'hFF); check1("post_rst_bl", bl_o[1], 1'b1);

    // Enable rising with a new index triggers no gap.
    apply(1'b1, 1'b0, 3'd3, 8'hFF);
    check8("en0_an", an_o[1], 8'hFF); check1("en0_bl", bl_o[1], 1'b0);
    apply(1'b1, 1'b1, 3'd3, 8'hFF);
    check8("en_rise_an", an_o[1], 8'hF7); check1("en_rise_bl", bl_o[1], 1'b0);

    // Randomized run against the model on every instance.
    apply(1'b0, 1'b1, 3'd0, 8'hFF);
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) data = 3'($urandom_range(0, 7));
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      tick();
      for (int i = 0; i < NI; i++) begin
        check8($sformatf("rnd%0d_u%0d_an", c, i), an_o[i], m_an[i]);
        check1($sformatf("rnd%0d_u%0d_bl", c, i), bl_o[i], m_bl[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/anode_decoder.md
# anode_decoder

Registered 3-to-8 digit-select decoder for the reaction-timer seven-segment display. It converts a binary digit index into a one-hot anode enable vector, active-low by default. It sits between the display scan logic and the board anode pins. Features: enable gating, per-digit blank mask, and an optional anti-ghosting gap when the selected digit changes.

## Interface
Parameters:
- ACTIVE_LOW, 1: 1 means a selected anode is driven 0 and idle anodes 1; 0 inverts this.
- NUM_DIGITS, 8: populated digits, 1..8. Anode bits at index NUM_DIGITS and above are always off.
- BLANK_CYCLES, 0: number of all-off cycles inserted when the digit index changes; 0 disables the gap.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- data  input  3  digit index to select.
- en  input  1  1 drives the anodes; 0 forces all anodes off.
- digit_mask  input  8  bit i = 0 forces anode i off.
- an  output  8  anode enables, registered; bit i selects digit i.
- blanking  output  1  registered; 1 while an anti-ghost gap is in progress.

## Operation
- "Off" value is 1 when ACTIVE_LOW=1 and 0 otherwise. "All-off" means every bit of an is at the off value.
- Internal state:
  - cur_sel: 3-bit index of the digit currently driven.
  - gap_cnt: wide enough to hold BLANK_CYCLES.
  - States: DRIVE when gap_cnt = 0, GAP when gap_cnt > 0.
- decode(s): one-hot on bit s, with bit s at the on value and all others off.
  - If s >= NUM_DIGITS, decode(s) is all-off.
  - Result is ANDed with digit_mask, so masked bits are forced to the off value.
- Actions at each rising clk, first matching rule wins:
  1. rst_n=0: an all-off; blanking=0; cur_sel=0; gap_cnt=0.
  2. en=0: an all-off; blanking=0; cur_sel<=data; gap_cnt<=0. No gap is triggered when en later rises.
  3. data != cur_sel and BLANK_CYCLES>0:
     - cur_sel<=data; an all-off.
     - gap_cnt<=BLANK_CYCLES-1.
     - blanking<=1 if BLANK_CYCLES>1, else 0.
     - A change during GAP restarts the gap with the new index.
  4. gap_cnt>0: gap_cnt decrements; an stays all-off; blanking<=(gap_cnt>1).
  5. Otherwise, DRIVE: an<=decode(data); cur_sel<=data; blanking<=0.
- With BLANK_CYCLES=0 the block is a pure registered decoder.
- digit_mask and en act on the next clock edge; they are not combinational.

## Timing
- Latency with BLANK_CYCLES=0: one cycle. data sampled at edge k appears on an after edge k.
- Latency on an index change with BLANK_CYCLES=N>0:
  - an is all-off for exactly N cycles.
  - The new one-hot appears after the (N+1)th edge following the change.
  - blanking covers the off cycles except the last.
- An unchanged data value holds an steady indefinitely.
- Reset mid-gap aborts the gap. an is all-off immediately after the reset edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with data=3 and en=1 -> an=8'hFF and blanking=0 after each edge.
- Sweep with ACTIVE_LOW=1, BLANK_CYCLES=0, en=1, digit_mask=8'hFF. Step data 0..7, changing 1 ns after each rising edge -> after the following edge, an = FE, FD, FB, F7, EF, DF, BF, 7F in turn.
- Gating and mask:
  - en=0 with data=2 -> an=8'hFF.
  - en=1, digit_mask=8'hFB, data=2 -> an=8'hFF.
  - Then data=1 -> an=8'hFD.
- Gap with BLANK_CYCLES=2: data steps 0->5 -> an=8'hFF for 2 cycles with blanking=1 in the first, then an=8'hDF. Changing data again during the gap restarts the 2-cycle gap.
- Range and polarity:
  - NUM_DIGITS=4, data=6 -> an=8'hFF.
  - ACTIVE_LOW=0, data=3 -> an=8'h08.
